// File: rtl/rr_decode_arbiter_if.sv
// rtl/rr_decode_arbiter_if.sv - request/grant bus between the clients and the round-robin arbiter
interface rr_decode_arbiter_if;
   logic [15:0] req;
   logic [15:0] gnt;
   logic [3:0]  gnt_idx;
   logic        gnt_valid;
   logic [15:0] grant_cnt;

   modport master (output req, input gnt, gnt_idx, gnt_valid, grant_cnt);
   modport slave  (input req, output gnt, gnt_idx, gnt_valid, grant_cnt);
endinterface

// File: rtl/rr_decode_arbiter.sv
// rtl/rr_decode_arbiter.sv - 16-way round-robin arbiter with hold cap and one-hot grant decode
module rr_decode_arbiter #(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 8
) (
   input logic                clk,
   input logic                rstn,
   rr_decode_arbiter_if.slave bus
);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

   state_t           r_state;
   logic [3:0]       r_ptr;
   logic [3:0]       r_idx;
   logic [15:0]      r_gnt;
   logic             r_valid;
   logic [CNT_W-1:0] r_hold;
   logic [15:0]      r_cnt;

   logic [3:0]       w_start;
   logic [3:0]       w_win;
   logic             w_found;
   logic             w_release;
   logic [15:0]      w_dec;

   // While granting, the search starts just past the owner, which is exactly the ptr a release installs.
   always_comb begin
      w_start = (r_state == S_GRANT) ? r_idx + 4'd1 : r_ptr;
   end

   // Scanning offsets from far to near leaves the nearest requester as the final winner.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int i = 15; i >= 0; i--) begin
         if (bus.req[w_start + 4'(i)]) begin
            w_found = 1'b1;
            w_win   = w_start + 4'(i);
         end
      end
   end

   always_comb begin
      w_dec     = 16'd1 << w_win;
      w_release = !bus.req[r_idx] || (r_hold == HOLD_MAX);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_idx   <= '0;
         r_gnt   <= '0;
         r_valid <= 1'b0;
         r_hold  <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_state <= S_GRANT;
                  r_idx   <= w_win;
                  r_gnt   <= w_dec;
                  r_valid <= 1'b1;
                  r_hold  <= CNT_W'(1);
                  r_cnt   <= r_cnt + 16'd1;
               end
            end
            S_GRANT: begin
               if (!w_release) begin
                  r_hold <= r_hold + CNT_W'(1);
               end else begin
                  r_ptr <= r_idx + 4'd1;
                  if (w_found) begin
                     r_idx  <= w_win;
                     r_gnt  <= w_dec;
                     r_hold <= CNT_W'(1);
                     r_cnt  <= r_cnt + 16'd1;
                  end else begin
                     r_state <= S_IDLE;
                     r_gnt   <= '0;
                     r_valid <= 1'b0;
                     r_hold  <= '0;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.gnt       = r_gnt;
   assign bus.gnt_idx   = r_idx;
   assign bus.gnt_valid = r_valid;
   assign bus.grant_cnt = r_cnt;

endmodule
